// File: rtl/bin_frame_buf_if.sv
// Handshake bundle between the pixel source / row consumer and bin_frame_buf.
// The slave modport is the buffer's view; master is the surrounding system's.
interface bin_frame_buf_if #(
   parameter int WIDTH = 28
);
   logic [7:0]       pix;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] row_data;
   logic             row_valid;
   logic             row_ready;
   logic             row_last;
   logic [7:0]       frame_cnt;

   modport master (
      output pix, in_valid, row_ready,
      input  in_ready, row_data, row_valid, row_last, frame_cnt
   );

   modport slave (
      input  pix, in_valid, row_ready,
      output in_ready, row_data, row_valid, row_last, frame_cnt
   );
endinterface

// File: rtl/bin_frame_buf.sv
// Binarizes an 8-bit pixel stream, packs WIDTH pixels per row, buffers one
// HEIGHT-row frame and then drains it row by row. Requires WIDTH >= 2.
module bin_frame_buf #(
   parameter int WIDTH  = 28,
   parameter int HEIGHT = 28,
   parameter int THRESH = 128
) (
   input  logic          clk,
   input  logic          xrst,
   bin_frame_buf_if.slave bus
);
   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t           r_state,     w_state_next;
   logic [COL_W-1:0] r_col,       w_col_next;
   logic [ROW_W-1:0] r_wr_row,    w_wr_row_next;
   logic [ROW_W-1:0] r_rd_row,    w_rd_row_next;
   logic [7:0]       r_frame_cnt, w_frame_cnt_next;

   // Only WIDTH-1 history bits are kept; the newest bit completes the row.
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_mem [HEIGHT];

   logic             w_bit;
   logic [WIDTH-1:0] w_row;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_col_end;
   logic             w_wr_end;
   logic             w_rd_end;

   assign w_bit      = (bus.pix >= 8'(THRESH));
   assign w_row      = {r_sr, w_bit};
   assign w_in_fire  = (r_state == S_FILL) && bus.in_valid;
   assign w_out_fire = (r_state == S_DRAIN) && bus.row_ready;
   assign w_col_end  = (r_col == COL_W'(WIDTH - 1));
   assign w_wr_end   = (r_wr_row == ROW_W'(HEIGHT - 1));
   assign w_rd_end   = (r_rd_row == ROW_W'(HEIGHT - 1));

   always_comb begin
      w_state_next     = r_state;
      w_col_next       = r_col;
      w_wr_row_next    = r_wr_row;
      w_rd_row_next    = r_rd_row;
      w_frame_cnt_next = r_frame_cnt;
      case (r_state)
         S_FILL: begin
            if (w_in_fire) begin
               if (w_col_end) begin
                  w_col_next = '0;
                  if (w_wr_end) begin
                     w_wr_row_next = '0;
                     w_state_next  = S_DRAIN;
                  end else begin
                     w_wr_row_next = r_wr_row + ROW_W'(1);
                  end
               end else begin
                  w_col_next = r_col + COL_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (w_out_fire) begin
               if (w_rd_end) begin
                  w_rd_row_next    = '0;
                  w_state_next     = S_FILL;
                  w_frame_cnt_next = r_frame_cnt + 8'd1;
               end else begin
                  w_rd_row_next = r_rd_row + ROW_W'(1);
               end
            end
         end
         default: w_state_next = S_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         r_state     <= S_FILL;
         r_col       <= '0;
         r_wr_row    <= '0;
         r_rd_row    <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_col       <= w_col_next;
         r_wr_row    <= w_wr_row_next;
         r_rd_row    <= w_rd_row_next;
         r_frame_cnt <= w_frame_cnt_next;
      end
   end

   // Datapath storage carries no reset; its contents are only observed in DRAIN.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_sr <= w_row[WIDTH-2:0];
         if (w_col_end)
            r_mem[r_wr_row] <= w_row;
      end
   end

   assign bus.in_ready  = (r_state == S_FILL);
   assign bus.row_valid = (r_state == S_DRAIN);
   assign bus.row_data  = (r_state == S_DRAIN) ? r_mem[r_rd_row] : '0;
   assign bus.row_last  = (r_state == S_DRAIN) && w_rd_end;
   assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_bin_frame_buf.sv
// Directed bench: a 4x2 instance for hand-checked frames and a 28x28 instance
// for a full default-size frame.
module tb_bin_frame_buf;
   logic clk = 1'b0;
   logic xrst;
   always #5 clk = ~clk;

   bin_frame_buf_if #(.WIDTH(4))  sb ();
   bin_frame_buf_if #(.WIDTH(28)) db ();

   bin_frame_buf #(.WIDTH(4), .HEIGHT(2), .THRESH(128)) dut_s (
      .clk  (clk),
      .xrst (xrst),
      .bus  (sb)
   );

   bin_frame_buf #(.WIDTH(28), .HEIGHT(28), .THRESH(128)) dut_d (
      .clk  (clk),
      .xrst (xrst),
      .bus  (db)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_s(input logic [7:0] p);
      sb.pix      = p;
      sb.in_valid = 1'b1;
      chk("s_in_ready", 32'(sb.in_ready), 32'd1);
      tick();
      sb.in_valid = 1'b0;
   endtask

   task automatic drain_s(input logic [3:0] r0, input logic [3:0] r1);
      sb.row_ready = 1'b1;
      chk("s_row0_valid", 32'(sb.row_valid), 32'd1);
      chk("s_row0_data",  32'(sb.row_data),  32'(r0));
      chk("s_row0_last",  32'(sb.row_last),  32'd0);
      tick();
      chk("s_row1_valid", 32'(sb.row_valid), 32'd1);
      chk("s_row1_data",  32'(sb.row_data),  32'(r1));
      chk("s_row1_last",  32'(sb.row_last),  32'd1);
      tick();
      sb.row_ready = 1'b0;
      chk("s_drained_valid", 32'(sb.row_valid), 32'd0);
      chk("s_drained_ready", 32'(sb.in_ready),  32'd1);
   endtask

   task automatic frame_s(input logic [63:0] px, input logic [3:0] r0, input logic [3:0] r1);
      for (int i = 0; i < 8; i++)
         push_s(px[63-8*i -: 8]);
      drain_s(r0, r1);
   endtask

   function automatic logic [7:0] pd(input int n);
      if (n < 11)
         return 8'd0;
      return ((((n - 11) / 5) % 2) == 0) ? 8'd255 : 8'd0;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [27:0] exp_row;
      logic        all_ready;

      xrst = 1'b1;
      sb.pix = 8'd0; sb.in_valid = 1'b0; sb.row_ready = 1'b0;
      db.pix = 8'd0; db.in_valid = 1'b0; db.row_ready = 1'b0;
      tick();
      tick();
      chk("rst_s_in_ready",  32'(sb.in_ready),  32'd1);
      chk("rst_s_row_valid", 32'(sb.row_valid), 32'd0);
      chk("rst_s_row_last",  32'(sb.row_last),  32'd0);
      chk("rst_s_row_data",  32'(sb.row_data),  32'd0);
      chk("rst_s_frame_cnt", 32'(sb.frame_cnt), 32'd0);
      chk("rst_d_in_ready",  32'(db.in_ready),  32'd1);
      chk("rst_d_row_valid", 32'(db.row_valid), 32'd0);
      xrst = 1'b0;
      tick();

      // Continuous stream, threshold boundaries, one-cycle latency to row_valid.
      push_s(8'd0); push_s(8'd255); push_s(8'd127); push_s(8'd128);
      push_s(8'd200); push_s(8'd0); push_s(8'd0);
      chk("s_valid_before_last", 32'(sb.row_valid), 32'd0);
      push_s(8'd255);
      drain_s(4'b0101, 4'b1001);
      chk("s_frame_cnt_1", 32'(sb.frame_cnt), 32'd1);

      // Same frame with in_valid gaps, then backpressure while pixels are offered.
      for (int i = 0; i < 8; i++) begin
         logic [63:0] px;
         px = 64'h00FF7F80C80000FF;
         repeat ($urandom_range(0, 2)) tick();
         push_s(px[63-8*i -: 8]);
      end
      sb.row_ready = 1'b0;
      sb.in_valid  = 1'b1;
      sb.pix       = 8'd255;
      for (int i = 0; i < 5; i++) begin
         chk("bp_row_valid", 32'(sb.row_valid), 32'd1);
         chk("bp_row_data",  32'(sb.row_data),  32'b0101);
         chk("bp_row_last",  32'(sb.row_last),  32'd0);
         chk("bp_in_ready",  32'(sb.in_ready),  32'd0);
         tick();
      end
      sb.in_valid = 1'b0;
      drain_s(4'b0101, 4'b1001);
      chk("s_frame_cnt_2", 32'(sb.frame_cnt), 32'd2);
      frame_s(64'hFFFF00000000FF00, 4'b1100, 4'b0010);
      chk("s_frame_cnt_3", 32'(sb.frame_cnt), 32'd3);

      // Asynchronous reset after 3 pixels of row 1, observed before the next edge.
      push_s(8'd0); push_s(8'd0); push_s(8'd0); push_s(8'd0);
      push_s(8'd255); push_s(8'd255); push_s(8'd255);
      #2 xrst = 1'b1;
      #1;
      chk("arst_in_ready",  32'(sb.in_ready),  32'd1);
      chk("arst_row_valid", 32'(sb.row_valid), 32'd0);
      chk("arst_frame_cnt", 32'(sb.frame_cnt), 32'd0);
      #1 xrst = 1'b0;
      tick();
      frame_s(64'hFF00FF0000FF00FF, 4'b1010, 4'b0101);
      chk("s_frame_cnt_after_rst", 32'(sb.frame_cnt), 32'd1);

      // Full default-size frame with row_ready held high.
      db.row_ready = 1'b1;
      all_ready = 1'b1;
      for (int n = 0; n < 784; n++) begin
         db.pix      = pd(n);
         db.in_valid = 1'b1;
         all_ready   = all_ready & db.in_ready;
         tick();
      end
      db.in_valid = 1'b0;
      chk("d_in_ready_fill", 32'(all_ready), 32'd1);
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++)
            exp_row[27-c] = (pd(r*28 + c) >= 8'd128);
         chk("d_row_valid", 32'(db.row_valid), 32'd1);
         chk("d_row_data",  32'(db.row_data),  32'(exp_row));
         chk("d_row_last",  32'(db.row_last),  32'(r == 27));
         tick();
      end
      chk("d_drained_valid", 32'(db.row_valid), 32'd0);
      chk("d_drained_ready", 32'(db.in_ready),  32'd1);
      chk("d_frame_cnt",     32'(db.frame_cnt), 32'd1);
      db.row_ready = 1'b0;

      // Frame counter wrap on the small instance.
      for (int f = 0; f < 254; f++)
         frame_s(64'h0, 4'b0000, 4'b0000);
      chk("s_frame_cnt_255", 32'(sb.frame_cnt), 32'd255);
      frame_s(64'hFFFFFFFFFFFFFFFF, 4'b1111, 4'b1111);
      chk("s_frame_cnt_wrap", 32'(sb.frame_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
